// File: rtl/ram_copy_engine.sv
// ram_copy_engine
//
// Copies a block of words from a source range to a destination range inside
// one single-port, registered-read RAM. Each word takes two cycles: a READ that
// presents the source address, then a WRITE that forwards the RAM read data to
// the destination address. The copy runs strictly forward, so an overlapping
// destination above the source propagates already-copied words.
//
// Optional feature macro: RAM_COPY_CHECKSUM_EN adds Checksum_o, which holds the
// running sum of all written words of the current command.
//
// Ports:
//   Clock             single clock, rising edge
//   Reset             synchronous, active-high
//   Start_i           command strobe, accepted only while idle
//   SrcAddress_i      first source word (sampled on accept)
//   DstAddress_i      first destination word (sampled on accept)
//   Length_i          word count, 0 is legal (sampled on accept)
//   Busy_o            high while a copy is in progress
//   Done_o            one-cycle completion pulse
//   RamReadEnable_o   RAM read enable
//   RamWriteEnable_o  RAM write enable
//   RamAddress_o      RAM address
//   RamData_o         RAM write data
//   RamData_i         RAM registered read data
//   Checksum_o        sum of written words (RAM_COPY_CHECKSUM_EN only)

module ram_copy_engine #(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned DATA_WIDTH    = 8
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     Start_i,
   input  logic [ADDRESS_WIDTH-1:0] SrcAddress_i,
   input  logic [ADDRESS_WIDTH-1:0] DstAddress_i,
   input  logic [ADDRESS_WIDTH-1:0] Length_i,
   output logic                     Busy_o,
   output logic                     Done_o,
   output logic                     RamReadEnable_o,
   output logic                     RamWriteEnable_o,
   output logic [ADDRESS_WIDTH-1:0] RamAddress_o,
   output logic [DATA_WIDTH-1:0]    RamData_o,
   input  logic [DATA_WIDTH-1:0]    RamData_i
`ifdef RAM_COPY_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]    Checksum_o
`endif
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StWrite = 2'd2
   } state_e;

   state_e                   state_q;
   logic [ADDRESS_WIDTH-1:0] src_q;
   logic [ADDRESS_WIDTH-1:0] dst_q;
   logic [ADDRESS_WIDTH-1:0] remaining_q;
   logic                     done_q;
   logic                     accept;

   assign accept = (state_q == StIdle) && Start_i;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= StIdle;
         src_q       <= '0;
         dst_q       <= '0;
         remaining_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (Start_i) begin
                  if (Length_i != '0) begin
                     src_q       <= SrcAddress_i;
                     dst_q       <= DstAddress_i;
                     remaining_q <= Length_i;
                     state_q     <= StRead;
                  end else begin
                     // Zero-length command completes without touching the RAM.
                     done_q <= 1'b1;
                  end
               end
            end
            StRead: begin
               state_q <= StWrite;
            end
            StWrite: begin
               // Address arithmetic wraps naturally at the register width.
               src_q       <= src_q + ADDRESS_WIDTH'(1);
               dst_q       <= dst_q + ADDRESS_WIDTH'(1);
               remaining_q <= remaining_q - ADDRESS_WIDTH'(1);
               if (remaining_q == ADDRESS_WIDTH'(1)) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= StRead;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // RAM side is decoded straight from the state register. In WRITE the RAM
   // still holds the word fetched in READ because its read enable is low.
   always_comb begin
      RamReadEnable_o  = 1'b0;
      RamWriteEnable_o = 1'b0;
      RamAddress_o     = '0;
      RamData_o        = '0;
      unique case (state_q)
         StRead: begin
            RamReadEnable_o = 1'b1;
            RamAddress_o    = src_q;
         end
         StWrite: begin
            RamWriteEnable_o = 1'b1;
            RamAddress_o     = dst_q;
            RamData_o        = RamData_i;
         end
         default: begin
         end
      endcase
   end

   assign Busy_o = (state_q != StIdle);
   assign Done_o = done_q;

`ifdef RAM_COPY_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] checksum_q;

   // Cleared on every accept (zero length included), so the value is final
   // from the Done_o cycle until the next command.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         checksum_q <= '0;
      end else if (accept) begin
         checksum_q <= '0;
      end else if (state_q == StWrite) begin
         checksum_q <= checksum_q + RamData_i;
      end
   end

   assign Checksum_o = checksum_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_ram_copy_engine.sv
module tb_ram_copy_engine;

   localparam int AW = 16;
   localparam int DW = 8;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Start_i;
   logic [AW-1:0] SrcAddress_i;
   logic [AW-1:0] DstAddress_i;
   logic [AW-1:0] Length_i;
   logic          Busy_o;
   logic          Done_o;
   logic          RamReadEnable_o;
   logic          RamWriteEnable_o;
   logic [AW-1:0] RamAddress_o;
   logic [DW-1:0] RamData_o;
   logic [DW-1:0] RamData_i;
`ifdef RAM_COPY_CHECKSUM_EN
   logic [DW-1:0] Checksum_o;
`endif

   always #5 Clock = ~Clock;

   ram_copy_engine #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW)
   ) dut (
      .Clock            (Clock),
      .Reset            (Reset),
      .Start_i          (Start_i),
      .SrcAddress_i     (SrcAddress_i),
      .DstAddress_i     (DstAddress_i),
      .Length_i         (Length_i),
      .Busy_o           (Busy_o),
      .Done_o           (Done_o),
      .RamReadEnable_o  (RamReadEnable_o),
      .RamWriteEnable_o (RamWriteEnable_o),
      .RamAddress_o     (RamAddress_o),
      .RamData_o        (RamData_o),
      .RamData_i        (RamData_i)
`ifdef RAM_COPY_CHECKSUM_EN
      ,
      .Checksum_o       (Checksum_o)
`endif
   );

   // RAM model: single address port, registered read, output held while idle.
   logic [DW-1:0] mem       [0:65535];
   logic [DW-1:0] model_mem [0:65535];
   logic [DW-1:0] rd_q;
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [DW-1:0] bd_data = '0;

   assign RamData_i = rd_q;

   always @(posedge Clock) begin
      if (RamReadEnable_o) rd_q <= mem[RamAddress_o];
      if (RamWriteEnable_o) mem[RamAddress_o] <= RamData_o;
      else if (bd_we) mem[bd_addr] <= bd_data;
   end

   int            checks   = 0;
   int            failures = 0;
   logic [23:0]   sb[$];
   logic [23:0]   sb_e;
   logic [DW-1:0] exp_sum;

   // Scoreboard consumer: every DUT write must match the next expected write.
   always @(negedge Clock) begin
      if (RamWriteEnable_o) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_write unexpected addr=%h data=%h required=no write",
                     RamAddress_o, RamData_o);
         end else begin
            sb_e = sb.pop_front();
            if ({RamAddress_o, RamData_o} !== sb_e) begin
               failures++;
               $display("FAIL sb_write got addr=%h data=%h required addr=%h data=%h",
                        RamAddress_o, RamData_o, sb_e[23:8], sb_e[7:0]);
            end
         end
      end
   end

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      model_mem[a] = d;
      bd_addr = a;
      bd_data = d;
      bd_we   = 1'b1;
      @(negedge Clock);
      bd_we   = 1'b0;
   endtask

   // Forward word-by-word reference copy; pushes each expected write.
   task automatic model_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input int n);
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      exp_sum = '0;
      for (int k = 0; k < n; k++) begin
         a = src + AW'(k);
         b = dst + AW'(k);
         model_mem[b] = model_mem[a];
         exp_sum = exp_sum + model_mem[b];
         sb.push_back({b, model_mem[b]});
      end
   endtask

   // Drives a command at a negedge; returns at the negedge of cycle 1.
   task automatic start_cmd(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input logic [AW-1:0] len);
      Start_i      = 1'b1;
      SrcAddress_i = src;
      DstAddress_i = dst;
      Length_i     = len;
      @(negedge Clock);
      Start_i      = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      Start_i = 1'b1;
      SrcAddress_i = 16'h0001;
      DstAddress_i = 16'h0002;
      Length_i = 16'h0003;
      repeat (3) @(negedge Clock);
      checks++;
      if ({Busy_o, Done_o, RamReadEnable_o, RamWriteEnable_o, RamAddress_o, RamData_o} !== '0)
      begin
         failures++;
         $display("FAIL reset_outputs got busy=%b done=%b re=%b we=%b addr=%h data=%h required all 0",
                  Busy_o, Done_o, RamReadEnable_o, RamWriteEnable_o, RamAddress_o, RamData_o);
      end
`ifdef RAM_COPY_CHECKSUM_EN
      checks++;
      if (Checksum_o !== '0) begin
         failures++;
         $display("FAIL reset_checksum got=%h required=00", Checksum_o);
      end
`endif
      Start_i = 1'b0;
      Reset = 1'b0;
      @(negedge Clock);
   endtask

   task automatic test_basic();
      logic [DW-1:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) preload(16'h0010 + AW'(i), pat[i]);
      model_copy(16'h0010, 16'h0100, 4);
      start_cmd(16'h0010, 16'h0100, 16'd4);
      for (int c = 1; c <= 12; c++) begin
         checks++;
         if (Busy_o !== (c <= 8)) begin
            failures++;
            $display("FAIL basic_busy cycle=%0d got=%b required=%b", c, Busy_o, (c <= 8));
         end
         checks++;
         if (Done_o !== (c == 9)) begin
            failures++;
            $display("FAIL basic_done cycle=%0d got=%b required=%b", c, Done_o, (c == 9));
         end
`ifdef RAM_COPY_CHECKSUM_EN
         if (c == 9) begin
            checks++;
            if (Checksum_o !== exp_sum || Checksum_o !== 8'hAA) begin
               failures++;
               $display("FAIL basic_checksum got=%h required=AA", Checksum_o);
            end
         end
`endif
         @(negedge Clock);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[16'h0100 + AW'(i)] !== pat[i]) begin
            failures++;
            $display("FAIL basic_mem idx=%0d got=%h required=%h", i, mem[16'h0100 + AW'(i)], pat[i]);
         end
      end
   endtask

   task automatic test_zero_length();
      start_cmd(16'h0010, 16'h0800, 16'd0);
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if ({Done_o, Busy_o, RamReadEnable_o, RamWriteEnable_o} !== {(c == 1), 3'b000}) begin
            failures++;
            $display("FAIL zero_len cycle=%0d got done=%b busy=%b re=%b we=%b required done=%b others 0",
                     c, Done_o, Busy_o, RamReadEnable_o, RamWriteEnable_o, (c == 1));
         end
`ifdef RAM_COPY_CHECKSUM_EN
         checks++;
         if (Checksum_o !== '0) begin
            failures++;
            $display("FAIL zero_len_checksum cycle=%0d got=%h required=00", c, Checksum_o);
         end
`endif
         @(negedge Clock);
      end
   endtask

   task automatic test_wrap();
      preload(16'hFFFE, 8'hA1);
      preload(16'hFFFF, 8'hB2);
      preload(16'h0000, 8'hC3);
      preload(16'h0001, 8'h00);
      model_copy(16'hFFFE, 16'hFFFF, 3);
      start_cmd(16'hFFFE, 16'hFFFF, 16'd3);
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if ({Busy_o, Done_o} !== {(c <= 6), (c == 7)}) begin
            failures++;
            $display("FAIL wrap_timing cycle=%0d got busy=%b done=%b required busy=%b done=%b",
                     c, Busy_o, Done_o, (c <= 6), (c == 7));
         end
         @(negedge Clock);
      end
      checks++;
      if ({mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000], mem[16'h0001]} !== {4{8'hA1}}) begin
         failures++;
         $display("FAIL wrap_mem got %h %h %h %h required a1 a1 a1 a1",
                  mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000], mem[16'h0001]);
      end
   endtask

   task automatic test_back_to_back();
      int ndone = 0;
      logic [DW-1:0] pat [4] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
      for (int i = 0; i < 4; i++) preload(16'h0020 + AW'(i), pat[i]);
      model_copy(16'h0020, 16'h0200, 4);
      start_cmd(16'h0020, 16'h0200, 16'd4);
      for (int c = 1; c <= 14; c++) begin
         if (Done_o === 1'b1) ndone++;
         checks++;
         if ({Busy_o, Done_o} !== {(c <= 8 || c == 10 || c == 11), (c == 9 || c == 12)}) begin
            failures++;
            $display("FAIL b2b_timing cycle=%0d got busy=%b done=%b required busy=%b done=%b",
                     c, Busy_o, Done_o, (c <= 8 || c == 10 || c == 11), (c == 9 || c == 12));
         end
`ifdef RAM_COPY_CHECKSUM_EN
         if (c == 12) begin
            checks++;
            if (Checksum_o !== 8'h5A) begin
               failures++;
               $display("FAIL b2b_checksum got=%h required=5a", Checksum_o);
            end
         end
`endif
         // Starts during the copy must be ignored; the one with Done_o is taken.
         if (c == 3 || c == 5) begin
            Start_i = 1'b1;
            SrcAddress_i = 16'h0070;
            DstAddress_i = 16'h0700;
            Length_i = 16'd2;
         end
         if (c == 4 || c == 6 || c == 10) Start_i = 1'b0;
         if (c == 9) begin
            Start_i = 1'b1;
            SrcAddress_i = 16'h0020;
            DstAddress_i = 16'h0300;
            Length_i = 16'd1;
            model_copy(16'h0020, 16'h0300, 1);
         end
         @(negedge Clock);
      end
      checks++;
      if (ndone != 2) begin
         failures++;
         $display("FAIL b2b_done_count got=%0d required=2", ndone);
      end
      checks++;
      if (mem[16'h0300] !== 8'h5A) begin
         failures++;
         $display("FAIL b2b_mem got=%h required=5a", mem[16'h0300]);
      end
   endtask

   task automatic test_reset_mid_copy();
      preload(16'h0040, 8'h01);
      preload(16'h0041, 8'h02);
      preload(16'h0042, 8'h03);
      preload(16'h0043, 8'h04);
      preload(16'h0402, 8'hEE);
      preload(16'h0403, 8'hEE);
      model_copy(16'h0040, 16'h0400, 2);
      start_cmd(16'h0040, 16'h0400, 16'd4);
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if (c <= 4) begin
            if (Busy_o !== 1'b1 || Done_o !== 1'b0) begin
               failures++;
               $display("FAIL rst_mid_busy cycle=%0d got busy=%b done=%b required busy=1 done=0",
                        c, Busy_o, Done_o);
            end
         end else if ({Busy_o, Done_o, RamReadEnable_o, RamWriteEnable_o, RamAddress_o,
                       RamData_o} !== '0) begin
            failures++;
            $display("FAIL rst_mid_idle cycle=%0d got busy=%b done=%b re=%b we=%b addr=%h data=%h required all 0",
                     c, Busy_o, Done_o, RamReadEnable_o, RamWriteEnable_o, RamAddress_o, RamData_o);
         end
`ifdef RAM_COPY_CHECKSUM_EN
         if (c == 5) begin
            checks++;
            if (Checksum_o !== '0) begin
               failures++;
               $display("FAIL rst_mid_checksum got=%h required=00", Checksum_o);
            end
         end
`endif
         if (c == 4) Reset = 1'b1;
         if (c == 5) Reset = 1'b0;
         @(negedge Clock);
      end
      checks++;
      if ({mem[16'h0400], mem[16'h0401], mem[16'h0402], mem[16'h0403]} !==
          {8'h01, 8'h02, 8'hEE, 8'hEE}) begin
         failures++;
         $display("FAIL rst_mid_mem got %h %h %h %h required 01 02 ee ee",
                  mem[16'h0400], mem[16'h0401], mem[16'h0402], mem[16'h0403]);
      end
      model_copy(16'h0042, 16'h0500, 1);
      start_cmd(16'h0042, 16'h0500, 16'd1);
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if ({Busy_o, Done_o} !== {(c <= 2), (c == 3)}) begin
            failures++;
            $display("FAIL rst_after_timing cycle=%0d got busy=%b done=%b required busy=%b done=%b",
                     c, Busy_o, Done_o, (c <= 2), (c == 3));
         end
         @(negedge Clock);
      end
      checks++;
      if (mem[16'h0500] !== 8'h03) begin
         failures++;
         $display("FAIL rst_after_mem got=%h required=03", mem[16'h0500]);
      end
   endtask

   initial begin
      Reset = 1'b1;
      Start_i = 1'b0;
      SrcAddress_i = '0;
      DstAddress_i = '0;
      Length_i = '0;
      @(negedge Clock);
      test_reset();
      test_basic();
      test_zero_length();
      test_wrap();
      test_back_to_back();
      test_reset_mid_copy();
      repeat (2) @(negedge Clock);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got=%0d pending writes required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_copy_engine.md
# ram_copy_engine

Master-side sequencer for the team's single-address-port, registered-read RAM. It drives read enable, write enable, address and write data, and consumes read data. It copies a block of words from a source address range to a destination address range inside the same RAM. Typical use is buffer duplication and region initialisation from a template, issued by a CPU or control FSM through a start/busy/done handshake.

## Interface
- ADDRESS_WIDTH, 16, RAM address width; also sets the width of Length_i.
- DATA_WIDTH, 8, RAM word width.

- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high.
- Start_i  in  1  command strobe; accepted only when Busy_o is 0.
- SrcAddress_i  in  ADDRESS_WIDTH  first source word; sampled on accept.
- DstAddress_i  in  ADDRESS_WIDTH  first destination word; sampled on accept.
- Length_i  in  ADDRESS_WIDTH  word count; sampled on accept; 0 is legal.
- Busy_o  out  1  high while a copy is in progress.
- Done_o  out  1  one-cycle completion pulse.
- RamReadEnable_o  out  1  to RAM read enable.
- RamWriteEnable_o  out  1  to RAM write enable.
- RamAddress_o  out  ADDRESS_WIDTH  to RAM address.
- RamData_o  out  DATA_WIDTH  to RAM write data.
- RamData_i  in  DATA_WIDTH  from RAM registered read data.
- Checksum_o  out  DATA_WIDTH  present only with RAM_COPY_CHECKSUM_EN.

## Operation
- States: IDLE, READ, WRITE.
- IDLE
  - Start_i=1 and Length_i≠0: latch src, dst and remaining=Length_i, then go to READ.
  - Start_i=1 and Length_i=0: stay in IDLE and pulse Done_o next cycle. No RAM access.
- READ: RamReadEnable_o=1, RamAddress_o=src. Always go to WRITE.
- WRITE
  - Drive RamWriteEnable_o=1, RamAddress_o=dst, RamData_o=RamData_i.
  - RamData_i is valid here because the RAM holds its output while read enable is low.
  - Then src+=1, dst+=1, remaining-=1.
  - If remaining was 1, go to IDLE with Done_o=1; otherwise go to READ.
- RAM strobes, address and data are decoded from the state register. RamAddress_o and RamData_o are 0 in IDLE.
- Busy_o = (state≠IDLE).
- Done_o is registered: high exactly one cycle, in the first IDLE cycle after the last WRITE, or in the cycle after a zero-length accept.
- Start_i while Busy_o=1 is ignored; it is neither queued nor errored.
- A Start_i in the same cycle as Done_o is accepted normally.
- Address arithmetic is modulo 2^ADDRESS_WIDTH, so src and dst wrap from all-ones to 0.
- Overlap: the copy is strictly forward, word by word. If dst lies in (src, src+Length), source words are overwritten before being read; this propagation is defined, required behaviour.
- Maximum Length is 2^ADDRESS_WIDTH−1.

## Timing
- Reset values: state IDLE, Busy_o=0, Done_o=0, all Ram* outputs 0, Checksum_o=0. Internal src, dst and remaining are 0.
- Accept at edge E0. READ occupies cycle 1 and WRITE occupies cycle 2.
- Each word costs 2 cycles. The write of word k (0-based) is in cycle 2k+2.
- Done_o is high in cycle 2N+1, counted as cycles after the accept edge, with Busy_o=0.
- Zero length: Done_o is high in cycle 1 and Busy_o stays 0.
- Reset asserted mid-copy: the RAM access already presented in that cycle completes at the edge. The next cycle is IDLE with all outputs at reset values. No Done_o is produced.
- Reset has priority over Start_i in the same cycle.

## Configuration
- RAM_COPY_CHECKSUM_EN defined:
  - Checksum_o exists. It is cleared to 0 on every accepted Start_i, including zero length.
  - Each WRITE adds RamData_o to it, modulo 2^DATA_WIDTH.
  - Its value is stable and final from the Done_o cycle until the next accept.
- Not defined: the Checksum_o port and its adder are absent. Copy behaviour and timing are identical either way.

## Test plan
- Copy src=0x0010, dst=0x0100, Length=4 with RAM[0x10..0x13]=11,22,33,44 -> RAM[0x100..0x103]=11,22,33,44; Done_o in cycle 9; Busy_o high in cycles 1–8; with macro, Checksum_o=0xAA.
- Length=0 -> Done_o in cycle 1 only; RamReadEnable_o and RamWriteEnable_o never asserted; Busy_o stays 0.
- Wrap: src=0xFFFE, dst=0xFFFF, Length=3, with RAM[0xFFFE]=A1, RAM[0xFFFF]=B2, RAM[0x0000]=C3 -> forward propagation gives RAM[0xFFFF]=A1, RAM[0x0000]=A1, RAM[0x0001]=A1; addresses wrap with no stall.
- Start_i pulsed in cycles 3 and 5 during a Length=4 copy -> ignored; exactly one Done_o. A Start_i coinciding with Done_o is accepted, and Busy_o stays 0 in that cycle.
- Reset high in cycle 4, the WRITE of word 1, of a Length=4 copy -> words 0 and 1 are written; next cycle is IDLE with all outputs 0; no Done_o; a subsequent Start_i runs normally.
